// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU operation arbiter.
//   - op codes for the 4-op datapath (mul, cat, exp, and)
//   - arbiter FSM state encoding
//   - default operand/result widths
package alu_arb_pkg;

    localparam int W_DEF  = 2;
    localparam int OW_DEF = 5;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_CAT = 2'd1,
        OP_EXP = 2'd2,
        OP_AND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant (first set bit at or after ptr_i, wrapping)
//   idx_o   : index of the granted bit
//   any_o   : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int unsigned pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (i + 32'(ptr_i)) % 32'(NREQ);
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one 4-op datapath among NREQ requesters, one operation in flight.
// Round-robin grant in IDLE, operands driven to the datapath, result sampled
// after a fixed DP_LAT and returned with the requester id.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_a/req_b/req_op       packed per-requester operands and op code
//   rsp_valid/rsp_ready      response handshake; rsp_id/rsp_data/rsp_err payload
//   dp_ina/dp_inb/dp_sel     datapath operands and op select
//   dp_outa                  datapath result
//   busy                     high whenever the FSM is not IDLE
//
// Build option: OP_EXP_EN. When undefined, op 2 (exp) is accepted but not
// issued; it is answered the next cycle with rsp_err=1 and rsp_data=0.
module alu_op_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DP_LAT = 2,
    parameter int W      = W_DEF,
    parameter int OW     = OW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [OW-1:0]           rsp_data,
    output logic                    rsp_err,
    output logic [W-1:0]            dp_ina,
    output logic [W-1:0]            dp_inb,
    output logic [1:0]              dp_sel,
    input  logic [OW-1:0]           dp_outa,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    // Counter only needs to hold DP_LAT-1.
    localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q;
    logic [W-1:0]    dp_ina_q, dp_inb_q;
    logic [1:0]      dp_sel_q;
    logic            rsp_valid_q, rsp_err_q;
    logic [IW-1:0]   rsp_id_q;
    logic [OW-1:0]   rsp_data_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [W-1:0]    sel_a, sel_b;
    logic [1:0]      sel_op;
    logic            sel_reject;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign sel_a  = req_a[int'(gnt_idx)*W +: W];
    assign sel_b  = req_b[int'(gnt_idx)*W +: W];
    assign sel_op = req_op[int'(gnt_idx)*2 +: 2];

`ifdef OP_EXP_EN
    assign sel_reject = 1'b0;
`else
    assign sel_reject = (op_e'(sel_op) == OP_EXP);
`endif

    assign rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

    // Accept strobe is combinational; masked in reset so all outputs read 0.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign busy      = (state_q != IDLE);
    assign dp_ina    = dp_ina_q;
    assign dp_inb    = dp_inb_q;
    assign dp_sel    = dp_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // The dp_* registers double as the operand latch: they load at accept so
    // the datapath sees stable inputs from the ISSUE cycle onward, and a
    // rejected op never touches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            dp_ina_q    <= '0;
            dp_inb_q    <= '0;
            dp_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (sel_reject) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_id_q    <= gnt_idx;
                            state_q     <= RESP;
                        end else begin
                            dp_ina_q <= sel_a;
                            dp_inb_q <= sel_b;
                            dp_sel_q <= sel_op;
                            id_q     <= gnt_idx;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= CW'(DP_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= dp_outa;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_id_q    <= '0;
                        rsp_data_q  <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_arbiter.sv
`timescale 1ns/1ps
module tb_alu_op_arbiter;

    localparam int NREQ   = 4;
    localparam int DP_LAT = 2;
    localparam int W      = 2;
    localparam int OW     = 5;
    localparam int IW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ*2-1:0] req_op;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IW-1:0]     rsp_id;
    logic [OW-1:0]     rsp_data;
    logic [W-1:0]      dp_ina, dp_inb;
    logic [1:0]        dp_sel;
    logic [OW-1:0]     dp_outa;
    logic              busy;

    always #5 clk = ~clk;

    alu_op_arbiter #(
        .NREQ   (NREQ),
        .DP_LAT (DP_LAT),
        .W      (W),
        .OW     (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dp_ina    (dp_ina),
        .dp_inb    (dp_inb),
        .dp_sel    (dp_sel),
        .dp_outa   (dp_outa),
        .busy      (busy)
    );

    function automatic logic [OW-1:0] alu_ref(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a * b;
            1:       r = a * 4 + b;
            2:       r = a ** b;
            default: r = a & b;
        endcase
        return OW'(r);
    endfunction

    // Datapath model: result appears DP_LAT cycles after inputs become stable.
    logic [OW-1:0] dp_pipe [DP_LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= alu_ref(int'(dp_ina), int'(dp_inb), int'(dp_sel));
        for (int k = 1; k < DP_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign dp_outa = dp_pipe[DP_LAT-1];

    typedef struct {
        int id;
        int data;
        int err;
        int acc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_ptr = 0;
    bit   prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Arbitration model and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int g, j, a, b, op, e;
        logic [NREQ-1:0] exp_rdy;
        exp_t x;
        if (rst) begin
            sb.delete();
            exp_ptr    = 0;
            prev_valid = 1'b0;
        end else begin
            if (busy) begin
                if (|req_valid) check("ready_while_busy", 32'(req_ready), 0);
            end else begin
                g = -1;
                exp_rdy = '0;
                for (int k = 0; k < NREQ; k++) begin
                    j = (exp_ptr + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                if (|req_valid || |req_ready) check("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (g >= 0) begin
                    a  = int'(req_a[g*W +: W]);
                    b  = int'(req_b[g*W +: W]);
                    op = int'(req_op[g*2 +: 2]);
`ifdef OP_EXP_EN
                    e = 0;
`else
                    e = (op == 2) ? 1 : 0;
`endif
                    x.id   = g;
                    x.err  = e;
                    x.data = e ? 0 : int'(alu_ref(a, b, op));
                    x.acc  = cyc;
                    x.lat  = e ? 1 : 2 + DP_LAT;
                    sb.push_back(x);
                    grant_log.push_back(g);
                    grant_cyc.push_back(cyc);
                    exp_ptr = (g + 1) % NREQ;
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 0);
                end else begin
                    if (!prev_valid) check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
                    check("rsp_id", 32'(rsp_id), sb[0].id);
                    check("rsp_data", 32'(rsp_data), sb[0].data);
                    check("rsp_err", 32'(rsp_err), sb[0].err);
                    check("busy_in_resp", 32'(busy), 1);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        prev_valid = 1'b0;
                    end else begin
                        prev_valid = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 40);
        check("grant_seen", 32'(req_ready[id]), 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drive_req(input int id, input int a, input int b, input int op);
        @(posedge clk); #1;
        req_a[id*W +: W]  = W'(a);
        req_b[id*W +: W]  = W'(b);
        req_op[id*2 +: 2] = 2'(op);
        req_valid[id]     = 1'b1;
        wait_grant(id);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 60);
        check("idle_reached", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct { int a; int b; int op; } vec_t;
    vec_t vecs [7] = '{'{2,3,1}, '{2,3,2}, '{2,3,3}, '{3,3,1}, '{3,3,2}, '{3,3,3}, '{3,3,0}};

    initial begin
        logic [W-1:0] s_ina, s_inb;
        logic [1:0]   s_sel;
        int base, n;
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_dp_sel", 32'(dp_sel), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single mul from requester 0.
        drive_req(0, 2, 3, 0);
        wait_idle();

        // Op table from requester 1.
        foreach (vecs[i]) begin
            drive_req(1, vecs[i].a, vecs[i].b, vecs[i].op);
            wait_idle();
        end

`ifndef OP_EXP_EN
        // Rejected exp leaves the datapath inputs untouched.
        s_ina = dp_ina; s_inb = dp_inb; s_sel = dp_sel;
        drive_req(0, 2, 3, 2);
        check("rej_dp_sel", 32'(dp_sel), 32'(s_sel));
        check("rej_dp_ina", 32'(dp_ina), 32'(s_ina));
        check("rej_dp_inb", 32'(dp_inb), 32'(s_inb));
        check("rej_rsp_err", 32'(rsp_err), 1);
        wait_idle();
`endif

        // Back-pressure: response held, competing request must wait.
        rsp_ready = 1'b0;
        drive_req(3, 1, 2, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        @(posedge clk); #1;
        req_a[2*W +: W] = 2'd3; req_b[2*W +: W] = 2'd1; req_op[2*2 +: 2] = 2'd0;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_data", 32'(rsp_data), 32'(alu_ref(1, 2, 1)));
            check("hold_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grant(2);
        wait_idle();

        // Reset in WAIT: everything clears, no response for the lost op.
        drive_req(1, 3, 2, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_rsp_id", 32'(rsp_id), 0);
        check("arst_rsp_err", 32'(rsp_err), 0);
        check("arst_dp", 32'({dp_ina, dp_inb, dp_sel}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_no_rsp", 32'(rsp_valid), 0);

        // All requesters held: round-robin order from index 0.
        base = grant_log.size();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W]  = W'(i);
            req_b[i*W +: W]  = W'(3 - i);
            req_op[i*2 +: 2] = 2'(i % 2);
        end
        req_valid = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_log.size() < base + 5 && n < 80);
        @(posedge clk); #1;
        req_valid = '0;
        check("rr_count", grant_log.size() - base, 5);
        if (grant_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", grant_log[base+i], i % NREQ);
            for (int i = 1; i < 5; i++)
                check("rr_spacing", grant_cyc[base+i] - grant_cyc[base+i-1], DP_LAT + 3);
        end
        wait_idle();
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
